// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multi-cycle control FSM
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_TRAP = 3'd7
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    // Instruction class latched in ID and consumed by EX/MEM/WB
    typedef enum logic [3:0] {
        CLS_R    = 4'd0,
        CLS_JR   = 4'd1,
        CLS_LW   = 4'd2,
        CLS_SW   = 4'd3,
        CLS_ADDI = 4'd4,
        CLS_ANDI = 4'd5,
        CLS_LUI  = 4'd6,
        CLS_BEQ  = 4'd7,
        CLS_J    = 4'd8,
        CLS_JAL  = 4'd9,
        CLS_ILL  = 4'd10
    } cls_e;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_FUNCT = 4'd2;
    localparam logic [3:0] ALU_AND   = 4'd3;
    localparam logic [3:0] ALU_LUI   = 4'd4;

    localparam logic [1:0] TC_NONE    = 2'b00;
    localparam logic [1:0] TC_ILLEGAL = 2'b01;
    localparam logic [1:0] TC_TIMEOUT = 2'b10;

    // ALU operation class used while an instruction executes in EX
    function automatic logic [3:0] alu_class(cls_e c);
        case (c)
            CLS_R:    return ALU_FUNCT;
            CLS_BEQ:  return ALU_SUB;
            CLS_ANDI: return ALU_AND;
            CLS_LUI:  return ALU_LUI;
            default:  return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - opcode/funct to instruction-class decoder
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output cls_e       cls_o
);

    // Pure lookup; unknown opcodes map to the illegal class
    always_comb begin
        cls_o = CLS_ILL;
        case (opcode_i)
            OP_RTYPE: cls_o = (funct_i == FN_JR) ? CLS_JR : CLS_R;
            OP_LW:    cls_o = CLS_LW;
            OP_SW:    cls_o = CLS_SW;
            OP_ADDI:  cls_o = CLS_ADDI;
            OP_ANDI:  cls_o = CLS_ANDI;
            OP_LUI:   cls_o = CLS_LUI;
            OP_BEQ:   cls_o = CLS_BEQ;
            OP_J:     cls_o = CLS_J;
            OP_JAL:   cls_o = CLS_JAL;
            default:  cls_o = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle datapath control FSM; optional perf counters via MC_CTRL_PERF_CNT_EN
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W     = 4,
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic               ext_op,
    output logic               lui_op,
    output logic [1:0]         mem_to_reg,
    output logic [1:0]         reg_dst,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_source,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               trap,
    output logic [1:0]         trap_cause,
    output logic [2:0]         state_o
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   instr_cnt
`endif
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    state_e     state_q, state_d;
    cls_e       cls_q;
    cls_e       dec_cls;
    logic [7:0] wait_q, wait_d;
    logic       trap_q, trap_d;
    logic [1:0] cause_q, cause_d;
    logic       timeout;
    logic [3:0] alu_cls;

    mc_ctrl_decode u_decode (
        .opcode_i (opcode),
        .funct_i  (funct),
        .cls_o    (dec_cls)
    );

    assign timeout    = (wait_q == TMO_LAST) && !mem_ready;
    assign state_o    = state_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign alu_op     = ALUOP_W'(alu_cls);

    // Next-state, sticky trap capture and memory wait counter
    always_comb begin
        state_d = state_q;
        trap_d  = trap_q;
        cause_d = cause_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IF: begin
                if (mem_ready) begin
                    state_d = ST_ID;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                    cause_d = TC_TIMEOUT;
                end
            end
            ST_ID: begin
                case (dec_cls)
                    CLS_JR, CLS_J, CLS_JAL: state_d = ST_IF;
                    CLS_ILL: begin
                        state_d = ST_TRAP;
                        cause_d = TC_ILLEGAL;
                    end
                    default: state_d = ST_EX;
                endcase
            end
            ST_EX: begin
                case (cls_q)
                    CLS_BEQ:        state_d = ST_IF;
                    CLS_LW, CLS_SW: state_d = ST_MEM;
                    default:        state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = (cls_q == CLS_LW) ? ST_WB : ST_IF;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                    cause_d = TC_TIMEOUT;
                end
            end
            ST_WB:   state_d = ST_IF;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IF;
        endcase
        if (state_d == ST_TRAP && state_q != ST_TRAP) begin
            trap_d = 1'b1;
        end
        if (state_d != state_q && (state_d == ST_IF || state_d == ST_MEM)) begin
            wait_d = '0;
        end else if ((state_q == ST_IF || state_q == ST_MEM) && !mem_ready) begin
            wait_d = wait_q + 8'd1;
        end
    end

    // State, latched instruction class, wait counter and trap registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IF;
            cls_q   <= CLS_R;
            wait_q  <= '0;
            trap_q  <= 1'b0;
            cause_q <= TC_NONE;
        end else begin
            state_q <= state_d;
            if (state_q == ST_ID) begin
                cls_q <= dec_cls;
            end
            wait_q  <= wait_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    // Datapath strobes and selects; only IF/MEM completion strobes see mem_ready
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        ext_op        = 1'b0;
        lui_op        = 1'b0;
        mem_to_reg    = 2'b00;
        reg_dst       = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_cls       = ALU_ADD;
        case (state_q)
            ST_IF: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            ST_ID: begin
                alu_src_b = 2'b11;
                case (dec_cls)
                    CLS_JR: begin
                        pc_write  = 1'b1;
                        pc_source = 2'b11;
                    end
                    CLS_J: begin
                        pc_write  = 1'b1;
                        pc_source = 2'b10;
                    end
                    CLS_JAL: begin
                        pc_write   = 1'b1;
                        pc_source  = 2'b10;
                        reg_write  = 1'b1;
                        reg_dst    = 2'b10;
                        mem_to_reg = 2'b10;
                    end
                    default: ;
                endcase
            end
            ST_EX: begin
                alu_src_a = 2'b01;
                alu_src_b = (cls_q == CLS_R || cls_q == CLS_BEQ) ? 2'b00 : 2'b10;
                ext_op    = (cls_q != CLS_ANDI);
                lui_op    = (cls_q == CLS_LUI);
                alu_cls   = alu_class(cls_q);
                if (cls_q == CLS_BEQ) begin
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
            end
            ST_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = (cls_q == CLS_LW);
                mem_write = (cls_q == CLS_SW);
            end
            ST_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (cls_q == CLS_R) ? 2'b01 : 2'b00;
                mem_to_reg = (cls_q == CLS_LW) ? 2'b01 : 2'b00;
            end
            default: ;
        endcase
    end

`ifdef MC_CTRL_PERF_CNT_EN
    // Cycle count outside TRAP and retired-instruction count on return to IF
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (state_q != ST_TRAP) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
            if (state_d == ST_IF && (state_q == ST_ID || state_q == ST_EX ||
                                     state_q == ST_MEM || state_q == ST_WB)) begin
                instr_cnt <= instr_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 Parameter ALUOP_W, default 4, SHALL set the alu_op width.
REQ-002 Parameter TIMEOUT_CYC, default 16, range 2..255, SHALL set the maximum number of cycles spent waiting for mem_ready.
REQ-003 Parameter CNT_W, default 32, SHALL set the performance-counter width.
REQ-004 Ports SHALL be, in order:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- mem_ready  in  1  memory access complete.
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write, ext_op, lui_op  out  1 each  datapath strobes.
- mem_to_reg, reg_dst, alu_src_a, alu_src_b, pc_source  out  2 each  mux selects.
- alu_op  out  ALUOP_W  ALU operation class.
- trap  out  1  sticky fault flag.
- trap_cause  out  2  01 illegal opcode, 10 memory timeout.
- state_o  out  3  current state.
- cycle_cnt, instr_cnt  out  CNT_W each  present only with the macro.

Function
REQ-005 The block SHALL be a Moore FSM with states IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=7.
REQ-006 IF SHALL assert mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01 (PC+4) and pc_source=00.
- On the cycle mem_ready=1, IF SHALL also assert ir_write=1 and pc_write=1, then go to ID.
- Otherwise it SHALL stay in IF.
REQ-007 ID SHALL drive alu_src_a=00, alu_src_b=11 (branch target) and decode opcode.
- 0x00 R-type: EX; funct 0x08 (jr) does a PC write with pc_source=11, then IF.
- 0x23 lw, 0x2B sw, 0x08 addi, 0x0C andi, 0x0F lui, 0x04 beq: EX.
- 0x02 j: pc_write=1, pc_source=10, then IF.
- 0x03 jal: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10, then IF.
- Any other opcode: trap=1, trap_cause=01, then TRAP.
REQ-008 EX SHALL drive alu_src_a=01 and, per instruction, alu_src_b=00 (register) or 10 (immediate).
- ext_op=0 for andi, 1 otherwise; lui_op=1 only for lui.
- beq SHALL assert pc_write_cond=1 and pc_source=01, then go to IF.
- lw and sw go to MEM; all others go to WB.
REQ-009 MEM SHALL assert i_or_d=1 and mem_read=1 (lw) or mem_write=1 (sw) until mem_ready.
- sw then goes to IF; lw goes to WB.
REQ-010 WB SHALL assert reg_write=1 for one cycle, then go to IF.
- reg_dst=01 for R-type, 00 otherwise.
- mem_to_reg=01 for lw, 00 otherwise.
REQ-011 alu_op encoding SHALL be: 0 add, 1 sub (beq), 2 funct-decoded (R-type), 3 and, 4 lui-pass. Upper bits SHALL be zero-padded when ALUOP_W>4.
REQ-012 A wait counter SHALL clear on entry to IF or MEM and increment each cycle without mem_ready.
- If it reaches TIMEOUT_CYC-1 with mem_ready still 0, the next state SHALL be TRAP with trap_cause=10.
- If mem_ready=1 arrives on that same cycle, mem_ready SHALL win and no trap is raised.
REQ-013 TRAP SHALL drive all strobes to 0 and hold until reset. trap and trap_cause SHALL stay stable.
REQ-014 Every strobe not listed for a state SHALL be 0; every select not listed SHALL be 00.
REQ-015 Strobes SHALL be pure functions of state and latched decode, with no combinational path from mem_ready except the IF/MEM completion strobes in REQ-006/009.

Reset
REQ-016 While reset=0, the FSM SHALL be in IF with the wait counter at 0, trap=0, trap_cause=00 and counters at 0.
REQ-017 Reset asserted mid-access SHALL abandon the access; the first cycle after release SHALL be IF with mem_read=1.

Configuration
REQ-018 Macro MC_CTRL_PERF_CNT_EN defined:
- cycle_cnt SHALL increment every non-TRAP cycle.
- instr_cnt SHALL increment on each transition into IF from ID, EX, MEM or WB.
- Both SHALL wrap modulo 2^CNT_W.
REQ-019 Macro MC_CTRL_PERF_CNT_EN undefined: the counter ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-020 Package mc_ctrl_pkg SHALL hold the state encodings, opcode/funct constants, alu_op class constants and trap_cause codes.
REQ-021 Sub-module mc_ctrl_decode SHALL map opcode/funct to an instruction-class code; the FSM latches that class in ID.

Verification
REQ-022 Reset then add (op 0x00, funct 0x20) with mem_ready=1 every cycle -> states IF,ID,EX,WB,IF; reg_write=1 only in WB with reg_dst=01.
REQ-023 lw with mem_ready low for 3 cycles in MEM -> MEM lasts 4 cycles; WB follows with mem_to_reg=01; instr_cnt +1.
REQ-024 beq -> pc_write_cond=1 and pc_source=01 in EX for exactly one cycle; the next state is IF.
REQ-025 opcode 0x3F -> TRAP after ID with trap_cause=01; all strobes 0 for 10 cycles; reset=0 then 1 -> IF.
REQ-026 TIMEOUT_CYC=4 with mem_ready held 0 in IF -> TRAP on the 5th cycle, trap_cause=10.
- Repeat with mem_ready=1 on the 4th cycle -> ID, no trap.
REQ-027 Reset asserted in MEM of sw -> no mem_write after release; with the macro, both counters read 0.
